// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding,
// hazard-cause tags for the trace logger and the control bundle.
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } hz_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE          = 3'd0,
        CAUSE_MEM_WAIT      = 3'd1,
        CAUSE_REDIRECT      = 3'd2,
        CAUSE_REDIRECT_TAIL = 3'd3,
        CAUSE_LOAD_USE      = 3'd4,
        CAUSE_CSR_RAW       = 3'd5
    } hz_cause_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
    } hz_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_controller_counter.sv
// Saturating event counter with async active-low clear; tied to 0
// when the performance counters are not built.
module hazard_event_counter #(
    parameter int XLEN   = 32,
    parameter bit ENABLE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    output logic [XLEN-1:0] count
);

    if (ENABLE) begin : g_cnt
        logic [XLEN-1:0] q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                q <= '0;
            end else if (inc && (q != '1)) begin
                q <= q + XLEN'(1);
            end
        end

        assign count = q;
    end else begin : g_tie
        assign count = '0;
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline, sitting beside
// the ID/EX register, with saturating stall and redirect counters.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int REDIRECT_CYCLES = 1,
    parameter bit COUNTER_EN      = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      ID_rs1,
    input  logic [4:0]      ID_rs2,
    input  logic            ID_uses_rs1,
    input  logic            ID_uses_rs2,
    input  logic            ID_csr_read,
    input  logic [4:0]      EX_rd,
    input  logic            EX_memory_read,
    input  logic            EX_register_write_enable,
    input  logic            EX_csr_write_enable,
    input  logic            EX_redirect,
    input  logic            MEM_dmem_request,
    input  logic            MEM_dmem_ready,
    output logic            pc_stall,
    output logic            IF_ID_stall,
    output logic            IF_ID_flush,
    output logic            ID_EX_stall,
    output logic            ID_EX_flush,
    output logic            EX_MEM_stall,
    output logic [XLEN-1:0] stall_count,
    output logic [XLEN-1:0] flush_count
);

    localparam logic [2:0] RC_LOAD = REDIRECT_CYCLES[2:0];
    localparam bit         HAS_RC  = (REDIRECT_CYCLES != 0);

    hz_state_e  state_q, state_d;
    logic [2:0] rcnt_q, rcnt_d;
    logic       pend_q, pend_d;
    hz_cause_e  cause;
    hz_ctrl_t   ctrl;
    logic       mw, luh, csh, rs1_hit, rs2_hit;

    assign mw      = MEM_dmem_request & ~MEM_dmem_ready;
    assign rs1_hit = ID_uses_rs1 & (ID_rs1 == EX_rd);
    assign rs2_hit = ID_uses_rs2 & (ID_rs2 == EX_rd);
    assign luh     = EX_memory_read & EX_register_write_enable
                   & (EX_rd != 5'd0) & (rs1_hit | rs2_hit);
    assign csh     = EX_csr_write_enable & ID_csr_read;

    always_comb begin
        cause = CAUSE_NONE;
        unique case (state_q)
            RUN: begin
                if (mw)               cause = CAUSE_MEM_WAIT;
                else if (EX_redirect) cause = CAUSE_REDIRECT;
                else if (luh)         cause = CAUSE_LOAD_USE;
                else if (csh)         cause = CAUSE_CSR_RAW;
            end
            MEM_WAIT: begin
                // A redirect seen on the release cycle is the same event
                if (mw)                         cause = CAUSE_MEM_WAIT;
                else if (pend_q | EX_redirect)  cause = CAUSE_REDIRECT;
            end
            REDIRECT: begin
                if (mw)               cause = CAUSE_MEM_WAIT;
                else if (EX_redirect) cause = CAUSE_REDIRECT;
                else                  cause = CAUSE_REDIRECT_TAIL;
            end
            default: cause = CAUSE_NONE;
        endcase
    end

    always_comb begin
        ctrl = '0;
        unique case (cause)
            CAUSE_MEM_WAIT: begin
                ctrl.pc_stall     = 1'b1;
                ctrl.if_id_stall  = 1'b1;
                ctrl.id_ex_stall  = 1'b1;
                ctrl.ex_mem_stall = 1'b1;
            end
            CAUSE_REDIRECT: begin
                ctrl.if_id_flush = 1'b1;
                ctrl.id_ex_flush = 1'b1;
            end
            CAUSE_REDIRECT_TAIL: begin
                ctrl.if_id_flush = 1'b1;
            end
            CAUSE_LOAD_USE, CAUSE_CSR_RAW: begin
                ctrl.pc_stall    = 1'b1;
                ctrl.if_id_stall = 1'b1;
                ctrl.id_ex_flush = 1'b1;
            end
            default: ctrl = '0;
        endcase
        if (!reset) ctrl = '0;
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        pend_d  = pend_q;
        unique case (state_q)
            RUN: begin
                if (mw) begin
                    state_d = MEM_WAIT;
                    pend_d  = EX_redirect;
                end else if (EX_redirect && HAS_RC) begin
                    state_d = REDIRECT;
                    rcnt_d  = RC_LOAD;
                end
            end
            MEM_WAIT: begin
                if (mw) begin
                    pend_d = pend_q | EX_redirect;
                end else begin
                    pend_d = 1'b0;
                    if ((pend_q | EX_redirect) && HAS_RC) begin
                        state_d = REDIRECT;
                        rcnt_d  = RC_LOAD;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            REDIRECT: begin
                if (mw) begin
                    state_d = MEM_WAIT;
                    pend_d  = 1'b1;
                    rcnt_d  = 3'd0;
                end else if (EX_redirect) begin
                    rcnt_d = RC_LOAD;
                end else if (rcnt_q <= 3'd1) begin
                    state_d = RUN;
                    rcnt_d  = 3'd0;
                end else begin
                    rcnt_d = rcnt_q - 3'd1;
                end
            end
            default: begin
                state_d = RUN;
                rcnt_d  = 3'd0;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            rcnt_q  <= 3'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            pend_q  <= pend_d;
        end
    end

    assign pc_stall     = ctrl.pc_stall;
    assign IF_ID_stall  = ctrl.if_id_stall;
    assign IF_ID_flush  = ctrl.if_id_flush;
    assign ID_EX_stall  = ctrl.id_ex_stall;
    assign ID_EX_flush  = ctrl.id_ex_flush;
    assign EX_MEM_stall = ctrl.ex_mem_stall;

    hazard_event_counter #(
        .XLEN  (XLEN),
        .ENABLE(COUNTER_EN)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (ctrl.pc_stall),
        .count(stall_count)
    );

    hazard_event_counter #(
        .XLEN  (XLEN),
        .ENABLE(COUNTER_EN)
    ) u_flush_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (cause == CAUSE_REDIRECT && reset),
        .count(flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios plus random
// traffic against a behavioural model, on a wide and a narrow instance.
module tb_pipeline_hazard_controller;

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_MW   = 6'b110101;
    localparam logic [5:0] C_RD   = 6'b001010;
    localparam logic [5:0] C_TAIL = 6'b001000;
    localparam logic [5:0] C_LU   = 6'b110010;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] ID_rs1, ID_rs2, EX_rd;
    logic ID_uses_rs1, ID_uses_rs2, ID_csr_read;
    logic EX_memory_read, EX_register_write_enable;
    logic EX_csr_write_enable, EX_redirect;
    logic MEM_dmem_request, MEM_dmem_ready;

    logic pcs0, ifs0, iff0, ids0, idf0, exs0;
    logic pcs1, ifs1, iff1, ids1, idf1, exs1;
    logic [31:0] sc0, fc0;
    logic [3:0] sc1, fc1;
    wire [5:0] ctl0 = {pcs0, ifs0, iff0, ids0, idf0, exs0};
    wire [5:0] ctl1 = {pcs1, ifs1, iff1, ids1, idf1, exs1};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .XLEN(32), .REDIRECT_CYCLES(2), .COUNTER_EN(1'b1)
    ) dut0 (
        .clk(clk), .reset(reset),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .ID_csr_read(ID_csr_read), .EX_rd(EX_rd),
        .EX_memory_read(EX_memory_read),
        .EX_register_write_enable(EX_register_write_enable),
        .EX_csr_write_enable(EX_csr_write_enable),
        .EX_redirect(EX_redirect),
        .MEM_dmem_request(MEM_dmem_request),
        .MEM_dmem_ready(MEM_dmem_ready),
        .pc_stall(pcs0), .IF_ID_stall(ifs0), .IF_ID_flush(iff0),
        .ID_EX_stall(ids0), .ID_EX_flush(idf0), .EX_MEM_stall(exs0),
        .stall_count(sc0), .flush_count(fc0)
    );

    pipeline_hazard_controller #(
        .XLEN(4), .REDIRECT_CYCLES(0), .COUNTER_EN(1'b1)
    ) dut1 (
        .clk(clk), .reset(reset),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .ID_csr_read(ID_csr_read), .EX_rd(EX_rd),
        .EX_memory_read(EX_memory_read),
        .EX_register_write_enable(EX_register_write_enable),
        .EX_csr_write_enable(EX_csr_write_enable),
        .EX_redirect(EX_redirect),
        .MEM_dmem_request(MEM_dmem_request),
        .MEM_dmem_ready(MEM_dmem_ready),
        .pc_stall(pcs1), .IF_ID_stall(ifs1), .IF_ID_flush(iff1),
        .ID_EX_stall(ids1), .ID_EX_flush(idf1), .EX_MEM_stall(exs1),
        .stall_count(sc1), .flush_count(fc1)
    );

    task automatic idle();
        ID_rs1 = 5'd0; ID_rs2 = 5'd0; EX_rd = 5'd0;
        ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0; ID_csr_read = 1'b0;
        EX_memory_read = 1'b0; EX_register_write_enable = 1'b0;
        EX_csr_write_enable = 1'b0; EX_redirect = 1'b0;
        MEM_dmem_request = 1'b0; MEM_dmem_ready = 1'b0;
    endtask

    task automatic set_luh();
        EX_memory_read = 1'b1; EX_register_write_enable = 1'b1;
        EX_rd = 5'd5; ID_rs2 = 5'd5; ID_uses_rs2 = 1'b1;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        MEM_dmem_request = 1'b1;
        EX_redirect = 1'b1;
        #1;
        checks++;
        if (ctl0 !== C_NONE || ctl1 !== C_NONE) begin
            errors++;
            $display("FAIL reset_ctl: got %b/%b expected 0", ctl0, ctl1);
        end
        @(negedge clk);
        checks++;
        if (sc0 !== 32'd0 || fc0 !== 32'd0 || sc1 !== 4'd0 || fc1 !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d %0d %0d %0d expected 0", sc0, fc0, sc1, fc1);
        end
        apply_reset();
    endtask

    task automatic test_load_use();
        apply_reset();
        set_luh();
        #1;
        checks++;
        if (ctl0 !== C_LU) begin
            errors++;
            $display("FAIL luh_stall: got %b expected %b", ctl0, C_LU);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (ctl0 !== C_NONE || sc0 !== 32'd1) begin
            errors++;
            $display("FAIL luh_after: got %b cnt %0d expected 0 cnt 1", ctl0, sc0);
        end
        @(negedge clk);
        set_luh();
        EX_rd = 5'd0; ID_rs2 = 5'd0;
        #1;
        checks++;
        if (ctl0 !== C_NONE) begin
            errors++;
            $display("FAIL luh_x0: got %b expected 0", ctl0);
        end
        @(negedge clk);
        idle();
        EX_csr_write_enable = 1'b1; ID_csr_read = 1'b1;
        #1;
        checks++;
        if (ctl0 !== C_LU) begin
            errors++;
            $display("FAIL csr_raw: got %b expected %b", ctl0, C_LU);
        end
        @(negedge clk);
        idle();
        EX_memory_read = 1'b1; EX_register_write_enable = 1'b1;
        EX_rd = 5'd9; ID_rs1 = 5'd9; ID_uses_rs1 = 1'b0;
        #1;
        checks++;
        if (ctl0 !== C_NONE || sc0 !== 32'd2) begin
            errors++;
            $display("FAIL luh_unused: got %b cnt %0d expected 0 cnt 2", ctl0, sc0);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_redirect();
        logic [5:0] exp [4];
        exp[0] = C_RD; exp[1] = C_TAIL; exp[2] = C_TAIL; exp[3] = C_NONE;
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            idle();
            if (c == 0) EX_redirect = 1'b1;
            if (c == 2) set_luh();
            #1;
            checks++;
            if (ctl0 !== exp[c]) begin
                errors++;
                $display("FAIL redirect_c%0d: got %b expected %b", c, ctl0, exp[c]);
            end
            @(negedge clk);
        end
        checks++;
        if (fc0 !== 32'd1 || sc0 !== 32'd0) begin
            errors++;
            $display("FAIL redirect_cnt: got f%0d s%0d expected f1 s0", fc0, sc0);
        end
        idle();
    endtask

    task automatic test_mem_wait();
        apply_reset();
        MEM_dmem_request = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (ctl0 !== C_MW) begin
                errors++;
                $display("FAIL mw_c%0d: got %b expected %b", c, ctl0, C_MW);
            end
            @(negedge clk);
        end
        MEM_dmem_ready = 1'b1;
        #1;
        checks++;
        if (ctl0 !== C_NONE || sc0 !== 32'd4) begin
            errors++;
            $display("FAIL mw_ready: got %b cnt %0d expected 0 cnt 4", ctl0, sc0);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_redirect_in_wait();
        apply_reset();
        MEM_dmem_request = 1'b1;
        for (int c = 0; c < 4; c++) begin
            EX_redirect = (c == 1 || c == 2);
            #1;
            checks++;
            if (ctl0 !== C_MW) begin
                errors++;
                $display("FAIL rw_c%0d: got %b expected %b", c, ctl0, C_MW);
            end
            @(negedge clk);
        end
        EX_redirect = 1'b0;
        MEM_dmem_ready = 1'b1;
        #1;
        checks++;
        if (ctl0 !== C_RD || fc0 !== 32'd0) begin
            errors++;
            $display("FAIL rw_ready: got %b cnt %0d expected %b cnt 0", ctl0, fc0, C_RD);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (ctl0 !== C_TAIL || fc0 !== 32'd1) begin
            errors++;
            $display("FAIL rw_tail: got %b cnt %0d expected %b cnt 1", ctl0, fc0, C_TAIL);
        end
        @(negedge clk);
    endtask

    task automatic test_luh_and_redirect();
        apply_reset();
        set_luh();
        EX_redirect = 1'b1;
        #1;
        checks++;
        if (ctl0 !== C_RD || ctl1 !== C_RD) begin
            errors++;
            $display("FAIL luh_redir: got %b/%b expected %b", ctl0, ctl1, C_RD);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_saturation();
        apply_reset();
        MEM_dmem_request = 1'b1;
        repeat (20) @(negedge clk);
        MEM_dmem_ready = 1'b1;
        #1;
        checks++;
        if (sc1 !== 4'hF || sc0 !== 32'd20) begin
            errors++;
            $display("FAIL sat_stall: got %0d/%0d expected 15/20", sc1, sc0);
        end
        @(negedge clk);
        idle();
        EX_redirect = 1'b1;
        repeat (20) @(negedge clk);
        EX_redirect = 1'b0;
        #1;
        checks++;
        if (fc1 !== 4'hF || fc0 !== 32'd20 || ctl0 !== C_TAIL) begin
            errors++;
            $display("FAIL sat_flush: got %0d/%0d ctl %b expected 15/20 ctl %b",
                     fc1, fc0, ctl0, C_TAIL);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_abort();
        apply_reset();
        EX_redirect = 1'b1;
        @(negedge clk);
        idle();
        reset = 1'b0;
        #1;
        checks++;
        if (ctl0 !== C_NONE || fc0 !== 32'd0) begin
            errors++;
            $display("FAIL abort_redir: got %b cnt %0d expected 0 cnt 0", ctl0, fc0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (ctl0 !== C_NONE) begin
            errors++;
            $display("FAIL abort_redir_run: got %b expected 0", ctl0);
        end
        @(negedge clk);
        MEM_dmem_request = 1'b1;
        EX_redirect = 1'b1;
        @(negedge clk);
        EX_redirect = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        MEM_dmem_request = 1'b0;
        #1;
        checks++;
        if (ctl0 !== C_NONE || ctl1 !== C_NONE) begin
            errors++;
            $display("FAIL abort_wait: got %b/%b expected 0", ctl0, ctl1);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_random();
        int rc [2];
        logic [31:0] cmax [2];
        bit wait_m [2];
        bit pend_m [2];
        int left_m [2];
        logic [31:0] sc_m [2];
        logic [31:0] fc_m [2];
        logic [5:0] exp_c, got_c;
        logic [31:0] got_s, got_f;
        bit mwb, haz, fev;
        rc[0] = 2; rc[1] = 0;
        cmax[0] = 32'hFFFF_FFFF; cmax[1] = 32'd15;
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            wait_m[k] = 0; pend_m[k] = 0; left_m[k] = 0;
            sc_m[k] = 0; fc_m[k] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(0, 199) != 0);
            ID_rs1 = 5'($urandom_range(0, 3));
            ID_rs2 = 5'($urandom_range(0, 3));
            EX_rd = 5'($urandom_range(0, 3));
            ID_uses_rs1 = 1'($urandom);
            ID_uses_rs2 = 1'($urandom);
            ID_csr_read = ($urandom_range(0, 3) == 0);
            EX_memory_read = 1'($urandom);
            EX_register_write_enable = ($urandom_range(0, 3) != 0);
            EX_csr_write_enable = ($urandom_range(0, 3) == 0);
            EX_redirect = ($urandom_range(0, 6) == 0);
            MEM_dmem_request = ($urandom_range(0, 4) < 2);
            MEM_dmem_ready = 1'($urandom);
            #1;
            mwb = MEM_dmem_request && !MEM_dmem_ready;
            haz = (EX_memory_read && EX_register_write_enable && EX_rd != 0 &&
                   ((ID_uses_rs1 && ID_rs1 == EX_rd) ||
                    (ID_uses_rs2 && ID_rs2 == EX_rd))) ||
                  (EX_csr_write_enable && ID_csr_read);
            for (int k = 0; k < 2; k++) begin
                exp_c = C_NONE;
                fev = 0;
                if (!reset) begin
                    wait_m[k] = 0; pend_m[k] = 0; left_m[k] = 0;
                    sc_m[k] = 0; fc_m[k] = 0;
                end else if (wait_m[k]) begin
                    if (mwb) begin
                        exp_c = C_MW;
                        if (EX_redirect) pend_m[k] = 1;
                    end else begin
                        wait_m[k] = 0;
                        if (pend_m[k] || EX_redirect) begin
                            exp_c = C_RD; fev = 1; left_m[k] = rc[k];
                        end
                        pend_m[k] = 0;
                    end
                end else if (left_m[k] > 0) begin
                    if (mwb) begin
                        exp_c = C_MW; wait_m[k] = 1; pend_m[k] = 1; left_m[k] = 0;
                    end else if (EX_redirect) begin
                        exp_c = C_RD; fev = 1; left_m[k] = rc[k];
                    end else begin
                        exp_c = C_TAIL; left_m[k]--;
                    end
                end else begin
                    if (mwb) begin
                        exp_c = C_MW; wait_m[k] = 1; pend_m[k] = EX_redirect;
                    end else if (EX_redirect) begin
                        exp_c = C_RD; fev = 1; left_m[k] = rc[k];
                    end else if (haz) begin
                        exp_c = C_LU;
                    end
                end
                got_c = (k == 0) ? ctl0 : ctl1;
                got_s = (k == 0) ? sc0 : {28'd0, sc1};
                got_f = (k == 0) ? fc0 : {28'd0, fc1};
                checks++;
                if (got_c !== exp_c) begin
                    errors++;
                    $display("FAIL rnd_ctl%0d cyc %0d: got %b expected %b", k, cyc, got_c, exp_c);
                end
                checks++;
                if (got_s !== sc_m[k] || got_f !== fc_m[k]) begin
                    errors++;
                    $display("FAIL rnd_cnt%0d cyc %0d: got s%0d f%0d expected s%0d f%0d",
                             k, cyc, got_s, got_f, sc_m[k], fc_m[k]);
                end
                if (exp_c[5] && sc_m[k] != cmax[k]) sc_m[k]++;
                if (fev && fc_m[k] != cmax[k]) fc_m[k]++;
            end
            @(negedge clk);
        end
        idle();
        reset = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_redirect_in_wait();
        test_luh_and_redirect();
        test_saturation();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
